// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding and counter widths for the hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam int FLUSH_CNT_W = 3;
    localparam int LOAD_CNT_W  = 2;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        LOAD_WAIT,
        SLEEP
    } pipe_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// load_use_detect: combinational load-use compare between the EX load and the ID sources.
module load_use_detect (
    input  logic       ram_load_access_id_ex,
    input  logic       reg_wen_id_ex,
    input  logic [4:0] rd_ex,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used,
    input  logic       rs2_used,
    output logic       hazard
);

    always_comb begin
        hazard = ram_load_access_id_ex && reg_wen_id_ex && (rd_ex != 5'd0) &&
                 ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for PC, IF_ID and ID_EX (load-use, load latency, WFI, redirects).
// Optional PIPE_STALL_CNT_EN adds a saturating stall_cycles counter output.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        jump_flag_ex,
    input  logic        trap_enter,
    input  logic        irq_pending,
    input  logic        wait_for_interrupt,
    input  logic        bus_ready,
    input  logic        ram_load_access_id_ex,
    input  logic        reg_wen_id_ex,
    input  logic [4:0]  rd_ex,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used,
    input  logic        rs2_used,
    output logic        stall_front_n,
    output logic        stall_n,
    output logic        hold_flag,
    output logic        wfi_sleeping
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [LOAD_CNT_W-1:0]  LOAD_INIT  = LOAD_CNT_W'(LOAD_LAT - 1);

    pipe_state_e             state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [LOAD_CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic                    hazard;

    load_use_detect u_load_use (
        .ram_load_access_id_ex (ram_load_access_id_ex),
        .reg_wen_id_ex         (reg_wen_id_ex),
        .rd_ex                 (rd_ex),
        .rs1_id                (rs1_id),
        .rs2_id                (rs2_id),
        .rs1_used              (rs1_used),
        .rs2_used              (rs2_used),
        .hazard                (hazard)
    );

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        load_cnt_d    = load_cnt_q;
        stall_front_n = 1'b1;
        stall_n       = 1'b1;
        hold_flag     = 1'b0;
        wfi_sleeping  = 1'b0;
        if (rst_sync) begin
            hold_flag = 1'b1;
        end else if (trap_enter || jump_flag_ex) begin
            hold_flag   = 1'b1;
            state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            flush_cnt_d = FLUSH_INIT;
            load_cnt_d  = '0;
        end else if (state_q == FLUSH) begin
            hold_flag   = 1'b1;
            flush_cnt_d = flush_cnt_q - 1'b1;
            state_d     = (flush_cnt_q <= 1) ? RUN : FLUSH;
        end else if (!bus_ready) begin
            // Bus back-pressure freezes everything, including a parked WFI.
            stall_front_n = 1'b0;
            stall_n       = 1'b0;
            wfi_sleeping  = (state_q == SLEEP);
        end else if (state_q == LOAD_WAIT) begin
            stall_front_n = 1'b0;
            stall_n       = 1'b0;
            load_cnt_d    = load_cnt_q - 1'b1;
            state_d       = (load_cnt_q <= 1) ? RUN : LOAD_WAIT;
        end else if (state_q == SLEEP) begin
            stall_front_n = 1'b0;
            stall_n       = 1'b0;
            wfi_sleeping  = 1'b1;
            state_d       = irq_pending ? RUN : SLEEP;
        end else if (hazard) begin
            // ID_EX keeps moving so the bubble enters through the exception path.
            stall_front_n = 1'b0;
            state_d       = (LOAD_LAT > 1) ? LOAD_WAIT : RUN;
            load_cnt_d    = LOAD_INIT;
        end else if (wait_for_interrupt && !irq_pending) begin
            state_d = SLEEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((!stall_front_n || !stall_n) && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_sync)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized bench against a cycle-level behavioural model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;
    localparam int LL = 3;

    logic       clk = 1'b0;
    logic       rst_sync, jump_flag_ex, trap_enter, irq_pending, wait_for_interrupt, bus_ready;
    logic       ram_load_access_id_ex, reg_wen_id_ex, rs1_used, rs2_used;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       stall_front_n, stall_n, hold_flag, wfi_sleeping;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .LOAD_LAT(LL)) dut (
        .clk                   (clk),
        .rst_sync              (rst_sync),
        .jump_flag_ex          (jump_flag_ex),
        .trap_enter            (trap_enter),
        .irq_pending           (irq_pending),
        .wait_for_interrupt    (wait_for_interrupt),
        .bus_ready             (bus_ready),
        .ram_load_access_id_ex (ram_load_access_id_ex),
        .reg_wen_id_ex         (reg_wen_id_ex),
        .rd_ex                 (rd_ex),
        .rs1_id                (rs1_id),
        .rs2_id                (rs2_id),
        .rs1_used              (rs1_used),
        .rs2_used              (rs2_used),
        .stall_front_n         (stall_front_n),
        .stall_n               (stall_n),
        .hold_flag             (hold_flag),
        .wfi_sleeping          (wfi_sleeping)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cycles          (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: remaining flush cycles, remaining load-wait cycles, sleeping flag.
    int flush_rem = 0;
    int load_rem  = 0;
    bit sleeping  = 0;
    longint stalls = 0;

    initial begin
        bit e_front, e_stall, e_hold, e_sleep, haz, redir;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_sync              = (c < 2) || ($urandom_range(0, 59) == 0);
            trap_enter            = ($urandom_range(0, 29) == 0);
            jump_flag_ex          = ($urandom_range(0, 11) == 0);
            bus_ready             = ($urandom_range(0, 4) != 0);
            irq_pending           = ($urandom_range(0, 5) == 0);
            wait_for_interrupt    = ($urandom_range(0, 5) == 0);
            ram_load_access_id_ex = $urandom_range(0, 1) == 1;
            reg_wen_id_ex         = ($urandom_range(0, 3) != 0);
            rd_ex                 = 5'($urandom_range(0, 3));
            rs1_id                = 5'($urandom_range(0, 3));
            rs2_id                = 5'($urandom_range(0, 3));
            rs1_used              = $urandom_range(0, 1) == 1;
            rs2_used              = $urandom_range(0, 1) == 1;
            #1;
            haz = ram_load_access_id_ex && reg_wen_id_ex && rd_ex != 0 &&
                  ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));
            redir = trap_enter || jump_flag_ex;
            {e_front, e_stall, e_hold, e_sleep} = 4'b1100;
            if (rst_sync || redir || flush_rem > 0) {e_front, e_stall, e_hold, e_sleep} = 4'b1110;
            else if (!bus_ready) {e_front, e_stall, e_hold, e_sleep} = {3'b000, sleeping};
            else if (load_rem > 0) {e_front, e_stall, e_hold, e_sleep} = 4'b0000;
            else if (sleeping) {e_front, e_stall, e_hold, e_sleep} = 4'b0001;
            else if (haz) {e_front, e_stall, e_hold, e_sleep} = 4'b0100;
            check("stall_front_n", 32'(stall_front_n), 32'(e_front));
            check("stall_n", 32'(stall_n), 32'(e_stall));
            check("hold_flag", 32'(hold_flag), 32'(e_hold));
            check("wfi_sleeping", 32'(wfi_sleeping), 32'(e_sleep));
`ifdef PIPE_STALL_CNT_EN
            if (c > 0) check("stall_cycles", stall_cycles, 32'(stalls));
`endif
            if (rst_sync) begin
                flush_rem = 0; load_rem = 0; sleeping = 0; stalls = 0;
            end else begin
                if ((!e_front || !e_stall) && stalls < 64'hFFFF_FFFF) stalls++;
                if (redir) begin
                    flush_rem = FC - 1; load_rem = 0; sleeping = 0;
                end else if (flush_rem > 0) flush_rem--;
                else if (!bus_ready) ;
                else if (load_rem > 0) load_rem--;
                else if (sleeping) sleeping = !irq_pending;
                else if (haz) load_rem = LL - 1;
                else if (wait_for_interrupt && !irq_pending) sleeping = 1;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
